// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity-mode codes
// and the receive state machine encoding.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_BRKWAIT = 3'd5
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop line synchroniser plus three-point mid-bit majority vote.
// The vote is combinational and meaningful only on the tick where cnt = OSR/2+1.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OSR = 16,
    parameter int CW  = $clog2(OSR)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clken,
    input  logic          i_rx,
    input  logic [CW-1:0] i_cnt,
    output logic          o_rx_s,
    output logic          o_vote
);

    localparam logic [CW-1:0] CNT_S0 = CW'(OSR/2 - 1);
    localparam logic [CW-1:0] CNT_S1 = CW'(OSR/2);

    logic [1:0] sync_q;
    logic [1:0] smp_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= 2'b11;
            smp_q  <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], i_rx};
            if (i_clken) begin
                if (i_cnt == CNT_S0) smp_q[0] <= sync_q[1];
                if (i_cnt == CNT_S1) smp_q[1] <= sync_q[1];
            end
        end
    end

    assign o_rx_s = sync_q[1];
    // Third sample is the live synchronised line on the vote tick itself.
    assign o_vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & o_rx_s) | (smp_q[1] & o_rx_s);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, LSB-first shift register, parity,
// framing and break detection; all state advances on the baud-tick enable.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int OSR       = 16,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clken,
    input  logic              i_rx,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_dout_valid,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_break,
    output logic              o_busy
);

    localparam int CW = $clog2(OSR);
    localparam int BW = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] CNT_VOTE = CW'(OSR/2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    rx_state_e         state_q;
    logic [CW-1:0]     cnt_q;
    logic [BW-1:0]     bit_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_mis_q;
    logic              frm_mis_q;
    logic              zero_q;
    logic              stop_q;
    logic [DATA_W-1:0] dout_q;
    logic              vld_q;
    logic              perr_q;
    logic              ferr_q;
    logic              brk_q;

    logic rx_s;
    logic vote;

    uart_rx_sampler #(
        .OSR (OSR),
        .CW  (CW)
    ) u_sampler (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clken (i_clken),
        .i_rx    (i_rx),
        .i_cnt   (cnt_q),
        .o_rx_s  (rx_s),
        .o_vote  (vote)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_mis_q <= 1'b0;
            frm_mis_q <= 1'b0;
            zero_q    <= 1'b0;
            stop_q    <= 1'b0;
            dout_q    <= '0;
            vld_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (i_clken) begin
                cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                case (state_q)
                    ST_IDLE: begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q   <= ST_START;
                            cnt_q     <= CW'(1);
                            bit_q     <= '0;
                            par_mis_q <= 1'b0;
                            frm_mis_q <= 1'b0;
                            zero_q    <= 1'b1;
                            stop_q    <= 1'b0;
                        end
                    end
                    ST_START: begin
                        if (cnt_q == CNT_VOTE && vote) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= ST_DATA;
                            bit_q   <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (cnt_q == CNT_VOTE) begin
                            shift_q <= {vote, shift_q[DATA_W-1:1]};
                            if (vote) zero_q <= 1'b0;
                        end
                        if (cnt_q == CNT_LAST) begin
                            bit_q <= bit_q + 1'b1;
                            if (bit_q == BIT_LAST)
                                state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end
                    end
                    ST_PARITY: begin
                        if (cnt_q == CNT_VOTE) begin
                            par_mis_q <= (PARITY == PAR_ODD) ? ~(^shift_q ^ vote)
                                                             :  (^shift_q ^ vote);
                            if (vote) zero_q <= 1'b0;
                        end
                        if (cnt_q == CNT_LAST) state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (cnt_q == CNT_VOTE) begin
                            // Break is decided on the first stop bit; frames end half a bit early.
                            if (zero_q && !vote && !stop_q) begin
                                dout_q  <= '0;
                                perr_q  <= 1'b0;
                                ferr_q  <= 1'b1;
                                brk_q   <= 1'b1;
                                vld_q   <= 1'b1;
                                state_q <= ST_BRKWAIT;
                                cnt_q   <= '0;
                            end else if (STOP_BITS == 1 || stop_q) begin
                                dout_q  <= shift_q;
                                perr_q  <= par_mis_q;
                                ferr_q  <= frm_mis_q | ~vote;
                                brk_q   <= 1'b0;
                                vld_q   <= 1'b1;
                                state_q <= ST_IDLE;
                                cnt_q   <= '0;
                            end else begin
                                frm_mis_q <= frm_mis_q | ~vote;
                            end
                        end else if (cnt_q == CNT_LAST) begin
                            stop_q <= 1'b1;
                        end
                    end
                    ST_BRKWAIT: begin
                        cnt_q <= '0;
                        if (rx_s) state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_dout       = dout_q;
    assign o_dout_valid = vld_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_break      = brk_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 7E1, 8N2) driven from tick-timed
// line waveforms; expected words and flags come from the frame contents.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int OSR = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clken = 1'b0;
    logic rx [3];

    logic [7:0] d0;
    logic [6:0] d1;
    logic [7:0] d2;
    logic [8:0] dout [3];
    logic [2:0] vld, perr, ferr, brk, busy;

    assign dout[0] = {1'b0, d0};
    assign dout[1] = {2'b0, d1};
    assign dout[2] = {1'b0, d2};

    uart_rx_param #(.OSR(OSR), .DATA_W(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u_8n1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clken(clken), .i_rx(rx[0]),
        .o_dout(d0), .o_dout_valid(vld[0]), .o_parity_err(perr[0]),
        .o_frame_err(ferr[0]), .o_break(brk[0]), .o_busy(busy[0]));

    uart_rx_param #(.OSR(OSR), .DATA_W(7), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_7e1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clken(clken), .i_rx(rx[1]),
        .o_dout(d1), .o_dout_valid(vld[1]), .o_parity_err(perr[1]),
        .o_frame_err(ferr[1]), .o_break(brk[1]), .o_busy(busy[1]));

    uart_rx_param #(.OSR(OSR), .DATA_W(8), .PARITY(PAR_NONE), .STOP_BITS(2)) u_8n2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clken(clken), .i_rx(rx[2]),
        .o_dout(d2), .o_dout_valid(vld[2]), .o_parity_err(perr[2]),
        .o_frame_err(ferr[2]), .o_break(brk[2]), .o_busy(busy[2]));

    always #5 clk = ~clk;

    // Baud tick on every other clock so the frozen cycles are always exercised.
    initial forever begin
        @(negedge clk);
        clken = ~clken;
    end

    // Valid-cycle log: one entry per high cycle of o_dout_valid.
    int         pc [3] = '{0, 0, 0};
    logic [8:0] ld [3][16];
    logic [2:0] le [3][16];
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i] === 1'b1) begin
                ld[i][pc[i] & 15] <= dout[i];
                le[i][pc[i] & 15] <= {perr[i], ferr[i], brk[i]};
                pc[i] <= pc[i] + 1;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!clken) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive(int ch, logic v, int n);
        rx[ch] = v;
        ticks(n);
    endtask

    // Line bits: start, data LSB first, optional parity, stop(s). Bit L spans
    // floor(L*OSR*(100+skew)/100) ticks; spike flips line bit L for one tick mid-bit.
    task automatic send(int ch, logic [8:0] data, int nd, int par, logic pbit,
                        int nstop, logic s0, logic s1, int skew, int spike);
        logic lb [16];
        int   n;
        lb[0] = 1'b0;
        for (int i = 0; i < nd; i++) lb[1+i] = data[i];
        n = 1 + nd;
        if (par != 0) begin lb[n] = pbit; n++; end
        lb[n] = s0; n++;
        if (nstop == 2) begin lb[n] = s1; n++; end
        for (int L = 0; L < n; L++) begin
            int len;
            len = ((L+1)*OSR*(100+skew))/100 - (L*OSR*(100+skew))/100;
            if (L == spike) begin
                drive(ch, lb[L], 8);
                drive(ch, ~lb[L], 1);
                drive(ch, lb[L], len - 9);
            end else begin
                drive(ch, lb[L], len);
            end
        end
    endtask

    function automatic logic exp_perr(logic [8:0] data, int nd, int mode, logic pbit);
        logic x;
        x = pbit;
        for (int i = 0; i < nd; i++) x = x ^ data[i];
        if (mode == PAR_ODD)  return ~x;
        if (mode == PAR_EVEN) return x;
        return 1'b0;
    endfunction

    task automatic chk_frame(string tag, int ch, int k, logic [8:0] d, logic pe, logic fe, logic br);
        chk({tag, "_dout"}, ld[ch][k & 15], d);
        chk({tag, "_flags"}, le[ch][k & 15], {pe, fe, br});
    endtask

    initial begin
        int          base;
        logic [7:0]  a5;
        logic [8:0]  v;
        logic        pb;
        int          sp;
        logic [7:0]  b2b [4];
        int          skw [4];

        a5 = 8'hA5;
        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55; b2b[3] = 8'hAA;
        skw[0] = 3; skw[1] = -3; skw[2] = 3; skw[3] = -3;
        for (int i = 0; i < 3; i++) rx[i] = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_busy", busy, 3'b000);
        chk("rst_vld", vld, 3'b000);
        chk("rst_flags", {perr, ferr, brk}, 9'h0);
        chk("rst_dout0", dout[0], 9'h0);
        chk("rst_dout1", dout[1], 9'h0);
        chk("rst_dout2", dout[2], 9'h0);
        rst_n = 1'b1;
        ticks(20);

        // 8N1 0xA5 with pulse timing inside the stop bit
        base = pc[0];
        drive(0, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive(0, a5[i], 16);
        chk("a5_busy", busy[0], 1'b1);
        drive(0, 1'b1, 10);
        chk("a5_not_yet", pc[0] - base, 0);
        ticks(2);
        chk("a5_pulse", pc[0] - base, 1);
        chk("a5_vld_low", vld[0], 1'b0);
        ticks(36);
        chk("a5_count", pc[0] - base, 1);
        chk("a5_dout", d0, 8'hA5);
        chk("a5_flags", {perr[0], ferr[0], brk[0]}, 3'b000);
        chk("a5_idle", busy[0], 1'b0);

        // 8N1 random words
        for (int r = 0; r < 3; r++) begin
            v = 9'($urandom_range(0, 255));
            base = pc[0];
            send(0, v, 8, 0, 1'b0, 1, 1'b1, 1'b1, 0, -1);
            drive(0, 1'b1, 32);
            chk("rnd8_count", pc[0] - base, 1);
            chk_frame("rnd8", 0, base, v, 1'b0, 1'b0, 1'b0);
        end

        // 7E1: forced wrong parity, correct parity, then random parity bits
        base = pc[1];
        send(1, 9'h35, 7, 1, 1'b1, 1, 1'b1, 1'b1, 0, -1);
        drive(1, 1'b1, 32);
        send(1, 9'h35, 7, 1, 1'b0, 1, 1'b1, 1'b1, 0, -1);
        drive(1, 1'b1, 32);
        chk("7e1_count", pc[1] - base, 2);
        chk_frame("7e1_bad", 1, base, 9'h35, 1'b1, 1'b0, 1'b0);
        chk_frame("7e1_good", 1, base + 1, 9'h35, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            v  = 9'($urandom_range(0, 127));
            pb = 1'($urandom_range(0, 1));
            base = pc[1];
            send(1, v, 7, 1, pb, 1, 1'b1, 1'b1, 0, -1);
            drive(1, 1'b1, 32);
            chk("7e1_rnd_count", pc[1] - base, 1);
            chk_frame("7e1_rnd", 1, base, v, exp_perr(v, 7, PAR_EVEN, pb), 1'b0, 1'b0);
        end

        // 8N1 framing error, then a normal frame
        base = pc[0];
        send(0, 9'h3C, 8, 0, 1'b0, 1, 1'b0, 1'b1, 0, -1);
        drive(0, 1'b1, 32);
        v = 9'($urandom_range(1, 255));
        send(0, v, 8, 0, 1'b0, 1, 1'b1, 1'b1, 0, -1);
        drive(0, 1'b1, 32);
        chk("ferr_count", pc[0] - base, 2);
        chk_frame("ferr", 0, base, 9'h3C, 1'b0, 1'b1, 1'b0);
        chk_frame("ferr_next", 0, base + 1, v, 1'b0, 1'b0, 1'b0);

        // Short low glitch is rejected as a false start
        base = pc[0];
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 40);
        chk("glitch_count", pc[0] - base, 0);
        chk("glitch_idle", busy[0], 1'b0);

        // One-tick spike at the middle sample of a data bit
        v  = 9'($urandom_range(0, 255));
        sp = int'($urandom_range(1, 8));
        base = pc[0];
        send(0, v, 8, 0, 1'b0, 1, 1'b1, 1'b1, 0, sp);
        drive(0, 1'b1, 32);
        chk("spike_count", pc[0] - base, 1);
        chk_frame("spike", 0, base, v, 1'b0, 1'b0, 1'b0);

        // Break: line low for two frame times
        base = pc[0];
        drive(0, 1'b0, 320);
        chk("brk_count_low", pc[0] - base, 1);
        chk("brk_wait_busy", busy[0], 1'b1);
        drive(0, 1'b1, 40);
        chk("brk_count_high", pc[0] - base, 1);
        chk("brk_idle", busy[0], 1'b0);
        chk_frame("brk", 0, base, 9'h0, 1'b0, 1'b1, 1'b1);
        v = 9'($urandom_range(0, 255));
        send(0, v, 8, 0, 1'b0, 1, 1'b1, 1'b1, 0, -1);
        drive(0, 1'b1, 32);
        chk("brk_after_count", pc[0] - base, 2);
        chk_frame("brk_after", 0, base + 1, v, 1'b0, 1'b0, 1'b0);

        // 8N2: second stop bit low gives a framing error
        v = 9'($urandom_range(0, 255));
        base = pc[2];
        send(2, v, 8, 0, 1'b0, 2, 1'b1, 1'b0, 0, -1);
        drive(2, 1'b1, 40);
        chk("stop2_count", pc[2] - base, 1);
        chk_frame("stop2", 2, base, v, 1'b0, 1'b1, 1'b0);

        // 8N2: four back-to-back frames with alternating +/-3% rate skew
        base = pc[2];
        for (int f = 0; f < 4; f++)
            send(2, {1'b0, b2b[f]}, 8, 0, 1'b0, 2, 1'b1, 1'b1, skw[f], -1);
        drive(2, 1'b1, 32);
        chk("b2b_count", pc[2] - base, 4);
        for (int f = 0; f < 4; f++)
            chk_frame("b2b", 2, base + f, {1'b0, b2b[f]}, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a frame
        base = pc[2];
        drive(2, 1'b0, 16);
        drive(2, 1'b1, 16);
        drive(2, 1'b0, 10);
        chk("mid_busy", busy[2], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy[2], 1'b0);
        chk("arst_dout", d2, 8'h00);
        chk("arst_flags", {perr[2], ferr[2], brk[2], vld[2]}, 4'b0000);
        rx[2] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(2, 1'b1, 200);
        chk("arst_no_pulse", pc[2] - base, 0);
        v = 9'($urandom_range(0, 255));
        send(2, v, 8, 0, 1'b0, 2, 1'b1, 1'b1, 0, -1);
        drive(2, 1'b1, 32);
        chk("arst_after_count", pc[2] - base, 1);
        chk_frame("arst_after", 2, base, v, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor UART receiver for the peripherals UART subsystem. It adds the following over the current fixed-format receiver:
- configurable oversampling, data width, parity and stop bits;
- input synchroniser and 3-sample majority vote;
- false-start rejection;
- parity, framing and break error reporting.

It sits between the UART pad input and the RX FIFO/CSR logic, clocked by the system clock and advanced by the baud-tick enable.

Parameters:
OSR, 16, baud ticks per bit; even, 8..32.
DATA_W, 8, data bits per frame; 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits checked; 1 or 2.

Ports:
i_clk  in  1  system clock; one clock domain.
i_rst_n  in  1  reset; asynchronous, active-low.
i_clken  in  1  baud-tick enable, OSR ticks per bit; all state advances only when high.
i_rx  in  1  asynchronous serial line; idle high.
o_dout  out  DATA_W  received word; bit 0 is the first bit received.
o_dout_valid  out  1  one i_clk-cycle pulse per completed frame.
o_parity_err  out  1  parity mismatch for the frame in o_dout; 0 when PARITY = 0.
o_frame_err  out  1  a checked stop bit was sampled low.
o_break  out  1  break condition detected.
o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, shift register 0. The sync flops reset to 1.
- Synchroniser: i_rx passes through 2 flops on every i_clk, independent of i_clken. All line decisions use the synchronised signal rx_s.
- Tick counter cnt runs 0..OSR-1 within each bit. Samples are captured on ticks where cnt is OSR/2-1, OSR/2 and OSR/2+1. vote is the majority of the 3 samples and is valid on the tick where cnt = OSR/2+1.
- IDLE: on a tick with rx_s = 0, go to START with cnt = 1. Otherwise stay, with cnt = 0.
- START:
  - If vote = 1 at cnt = OSR/2+1, this is a false start: go to IDLE with no output.
  - If the start is good, at cnt = OSR-1 go to DATA with cnt = 0 and bit index = 0.
- DATA:
  - At vote time, shift vote into the shift register LSB-first.
  - At cnt = OSR-1 increment the bit index.
  - After DATA_W bits, go to PARITY if PARITY != 0, else go to STOP.
- PARITY:
  - Odd mode: the XOR of data bits and the parity bit must be 1.
  - Even mode: that XOR must be 0.
  - Store the mismatch flag. At cnt = OSR-1 go to STOP.
- STOP:
  - At vote time, a stop vote of 0 sets the frame-error flag.
  - If STOP_BITS = 2, the first stop bit completes at cnt = OSR-1 and the second is checked the same way.
  - At the vote of the last stop bit, finish the frame immediately (half-bit early exit, for tolerance to baud mismatch). Go to IDLE, or to BRKWAIT on a break.
- Frame completion timing: on the i_clk cycle after that tick, o_dout, o_parity_err, o_frame_err and o_break update together and o_dout_valid pulses high for exactly 1 cycle.
- Held outputs: o_dout and the error flags hold their values until the next completion.
- Break: all data votes 0, the parity vote 0 (if parity is enabled) and the first stop vote 0.
  - Report o_break = 1 and o_frame_err = 1 with o_dout = 0.
  - Then enter BRKWAIT; the completion rule above applies to this frame.
- BRKWAIT: stay until a tick with rx_s = 1, then go to IDLE. A new start is not accepted until the line returns high.
- i_clken low: state, cnt and samples freeze. The valid pulse still deasserts after 1 cycle.
- Asynchronous reset mid-frame: everything returns to reset values immediately, with no valid pulse for the partial frame.
- Widths:
  - cnt is $clog2(OSR) bits.
  - The bit index is $clog2(DATA_W+1) bits.
  - Parity is computed over DATA_W bits only.
- State encoding (IDLE, START, DATA, PARITY, STOP, BRKWAIT) lives in the package; the default branch returns to IDLE.

Decomposition:
- Package uart_pkg: parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN) and the rx state enum.
- Sub-module uart_rx_sampler: the 2-flop synchroniser plus 3-sample majority vote. Inputs: cnt and i_clken. Outputs: rx_s and vote.
- The FSM, shift register and error logic stay in uart_rx_param.

Test Plan:
- 8N1, OSR = 16: send 0xA5 at the exact rate → o_dout = 0xA5, one valid pulse, all error flags 0. The pulse arrives about 8.5 ticks plus 2 sync cycles into the stop bit.
- 7E1: send 0x35 with the parity bit forced to 1 → o_dout = 0x35 and o_parity_err = 1. The correct parity bit (0) gives o_parity_err = 0.
- 8N1: send 0x3C with the stop bit held low → o_frame_err = 1 and o_dout = 0x3C. Line high afterwards → the next frame is received normally.
- Glitches: a low pulse of 3 ticks → no output and back to IDLE. A 1-tick spike inside a data bit at the mid-sample position → the bit value is still correct, because the majority vote rejects it.
- Break: line low for 2 frame times → o_break = 1, o_frame_err = 1, o_dout = 0, exactly one valid pulse. No further frames until the line returns high.
- 8N2: 4 back-to-back frames 0x00, 0xFF, 0x55, 0xAA with OSR ±3% skew → all received in order. Assert i_rst_n low mid-frame → outputs go to 0 immediately and no valid pulse occurs.
